// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: snapshots the N*N accumulator results on a
// rising edge of done, then streams them row-major over a valid/ready interface.
module systolic_result_drain #(
    parameter int N      = 3,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  done,
    input  logic [N*N*DATA_W-1:0] c_flat,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [IDX_W-1:0]      m_index,
    output logic                  busy,
    output logic                  overrun,
    input  logic                  clr_err,
    output logic [7:0]            frame_cnt
);

    localparam int                WORDS    = N * N;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                done_d;
    logic                rise;
    logic                handshake;
    logic                at_last;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   result_buf [WORDS];

    assign rise      = done & ~done_d;
    assign at_last   = (idx == LAST_IDX);
    assign handshake = (state == SEND) && m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise) state_next = SEND;
            SEND:    if (handshake && at_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done_d resets high so a done level already present at reset release
    // must drop before it can start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_d    <= 1'b1;
            idx       <= '0;
            frame_cnt <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                result_buf[i] <= '0;
            end
        end else begin
            done_d <= done;
            if (state == IDLE && rise) begin
                idx <= '0;
                for (int i = 0; i < WORDS; i++) begin
                    result_buf[i] <= c_flat[i*DATA_W +: DATA_W];
                end
            end else if (handshake) begin
                if (at_last) begin
                    idx       <= '0;
                    frame_cnt <= frame_cnt + 8'd1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end

            // A new rise while a frame is held is dropped; set beats clear.
            if (state == SEND && rise) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign m_valid = (state == SEND);
    assign busy    = (state == SEND);
    assign m_index = idx;
    assign m_last  = (state == SEND) && at_last;
    assign m_data  = (state == SEND) ? result_buf[idx] : '0;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed self-checking bench for systolic_result_drain: inputs change and
// outputs are checked on the falling clock edge.
module tb_systolic_result_drain;

    localparam int N      = 3;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 4;

    logic                  clk;
    logic                  rst_n;
    logic                  done;
    logic [N*N*DATA_W-1:0] c_flat;
    logic [DATA_W-1:0]     m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [IDX_W-1:0]      m_index;
    logic                  busy;
    logic                  overrun;
    logic                  clr_err;
    logic [7:0]            frame_cnt;

    int vectors;
    int miscompares;

    systolic_result_drain #(.N(N), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .done      (done),
        .c_flat    (c_flat),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .m_index   (m_index),
        .busy      (busy),
        .overrun   (overrun),
        .clr_err   (clr_err),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadSequence();
        for (int i = 0; i < N*N; i++) begin
            c_flat[i*DATA_W +: DATA_W] = DATA_W'(i + 1);
        end
    endtask

    task automatic loadConstant(input logic [DATA_W-1:0] value);
        for (int i = 0; i < N*N; i++) begin
            c_flat[i*DATA_W +: DATA_W] = value;
        end
    endtask

    // Drop done for one cycle then raise it; returns just after the capture edge.
    task automatic applyStimulus();
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
    endtask

    task automatic checkBeat(input int k, input logic [DATA_W-1:0] value);
        checkOutput($sformatf("valid_%0d", k), 32'(m_valid), 32'd1);
        checkOutput($sformatf("data_%0d", k), 32'(m_data), 32'(value));
        checkOutput($sformatf("index_%0d", k), 32'(m_index), 32'(k));
        checkOutput($sformatf("last_%0d", k), 32'(m_last), (k == N*N-1) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int exp_idx;
        int cyc;
        logic rdy;

        vectors     = 0;
        miscompares = 0;
        rst_n   = 1'b0;
        done    = 1'b1;
        m_ready = 1'b0;
        clr_err = 1'b0;
        loadSequence();
        tick();
        tick();

        checkOutput("rst_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_last", 32'(m_last), 32'd0);
        checkOutput("rst_data", 32'(m_data), 32'd0);
        checkOutput("rst_index", 32'(m_index), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);

        // done held high across reset release must not start a frame
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("no_capture_%0d", i), 32'(m_valid), 32'd0);
        end
        checkOutput("no_capture_cnt", 32'(frame_cnt), 32'd0);

        // single frame, m_ready held high
        m_ready = 1'b1;
        applyStimulus();
        for (int k = 0; k < N*N; k++) begin
            checkBeat(k, DATA_W'(k + 1));
            tick();
        end
        checkOutput("frame1_valid_after", 32'(m_valid), 32'd0);
        checkOutput("frame1_busy_after", 32'(busy), 32'd0);
        checkOutput("frame1_cnt", 32'(frame_cnt), 32'd1);

        // backpressure with ready pattern 1,0,0,...
        m_ready = 1'b0;
        applyStimulus();
        exp_idx = 0;
        cyc     = 0;
        while (exp_idx < N*N && cyc < 60) begin
            checkBeat(exp_idx, DATA_W'(exp_idx + 1));
            rdy     = (cyc % 3 == 0);
            m_ready = rdy;
            tick();
            if (rdy) exp_idx++;
            cyc++;
        end
        checkOutput("bp_all_accepted", 32'(exp_idx), 32'(N*N));
        checkOutput("bp_valid_after", 32'(m_valid), 32'd0);
        checkOutput("bp_cnt", 32'(frame_cnt), 32'd2);

        // snapshot isolation: inputs change after capture
        m_ready = 1'b1;
        applyStimulus();
        loadConstant(16'hFFFF);
        for (int k = 0; k < N*N; k++) begin
            checkBeat(k, DATA_W'(k + 1));
            tick();
        end
        applyStimulus();
        for (int k = 0; k < N*N; k++) begin
            checkBeat(k, 16'hFFFF);
            tick();
        end
        checkOutput("snap_cnt", 32'(frame_cnt), 32'd4);

        // overrun: done toggles during beat 4
        loadSequence();
        applyStimulus();
        for (int k = 0; k < N*N; k++) begin
            checkBeat(k, DATA_W'(k + 1));
            if (k == 3) begin
                done = 1'b0;
                loadConstant(16'h5A5A);
            end
            if (k == 4) done = 1'b1;
            tick();
        end
        checkOutput("ovr_flag", 32'(overrun), 32'd1);
        checkOutput("ovr_valid_after", 32'(m_valid), 32'd0);
        tick();
        checkOutput("ovr_no_second_frame", 32'(m_valid), 32'd0);
        checkOutput("ovr_cnt", 32'(frame_cnt), 32'd5);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 32'd0);

        // reset in the middle of a frame
        loadSequence();
        applyStimulus();
        for (int k = 0; k < 5; k++) begin
            checkBeat(k, DATA_W'(k + 1));
            tick();
        end
        checkOutput("mid_index_before_reset", 32'(m_index), 32'd5);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(m_valid), 32'd0);
        checkOutput("mid_rst_data", 32'(m_data), 32'd0);
        checkOutput("mid_rst_index", 32'(m_index), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_cnt", 32'(frame_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_idle", 32'(m_valid), 32'd0);
        applyStimulus();
        checkBeat(0, DATA_W'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
# systolic_result_drain

Result-side companion to the 3x3 systolic multiplier top. Watches the array's `done` level, snapshots all N×N accumulator results in one cycle, then streams them out one word per beat, row-major, on a valid/ready interface toward the host/UART packer. Decouples the array from downstream backpressure, so the array may be restarted once the snapshot is taken.

## Interface
- `N`, 3, matrix dimension; the stream carries N*N words per frame.
- `DATA_W`, 16, width of one result element.
- `IDX_W`, 4, width of `m_index`; must satisfy 2^IDX_W ≥ N*N.

- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `done`  in  1  level from the array; high when results are valid.
- `c_flat`  in  N*N*DATA_W  results; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W].
- `m_data`  out  DATA_W  current result word.
- `m_valid`  out  1  `m_data` is valid.
- `m_ready`  in  1  downstream accepts a beat when `m_valid & m_ready`.
- `m_last`  out  1  high with the final word of a frame (index N*N-1).
- `m_index`  out  IDX_W  row-major index of the current word.
- `busy`  out  1  high while a frame is held or being streamed.
- `overrun`  out  1  sticky; a new `done` edge arrived while busy.
- `clr_err`  in  1  synchronous clear of `overrun`.
- `frame_cnt`  out  8  completed frames, wraps 255→0.

## Operation
- `done_d` registers `done`; `rise = done & ~done_d`. `done_d` resets to 1, so `done` already high at reset release is not a rise; `done` must be seen low first.
- FSM states: IDLE, SEND.
- IDLE: `m_valid`=0. On `rise`, all N*N words of `c_flat` go into an internal buffer in the same edge, index ← 0, go to SEND.
- SEND: `m_valid`=1, `m_data`=buf[index], `m_index`=index, `m_last`=(index==N*N-1). On a handshake with index<N*N-1: index+1. On a handshake with index==N*N-1: `frame_cnt`+1 (mod 256), go to IDLE.
- Buffer contents are frozen in SEND; `c_flat` changes have no effect until the next capture.
- `rise` in SEND (including the final-handshake cycle): set `overrun`, discard the new data, current frame continues unchanged. No queueing of a second frame.
- `clr_err` clears `overrun` on the next edge; if `clr_err` and a new overrun event coincide, set wins.
- `busy` = (state==SEND).
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `m_index`=0, `busy`=0, `overrun`=0, `frame_cnt`=0, buffer=0, state IDLE. Asserting reset mid-frame aborts it; the next frame restarts at index 0.

## Timing
- Capture latency: `done` sampled high at edge t with `done_d`=0 → `m_valid`=1 and word 0 visible after edge t (the cycle following `done`'s first high cycle).
- With `m_ready` held high, one word per cycle: N*N consecutive beats, `m_last` on beat N*N, `m_valid` low the cycle after.
- Minimum frame-to-frame spacing: N*N + 1 cycles (one IDLE cycle after the last beat). A rise in that IDLE cycle is captured.
- AXI-stream rules: once `m_valid` is high, it and `m_data`/`m_index`/`m_last` hold stable until the handshake. `m_valid` never depends combinationally on `m_ready`.
- All outputs are registered, or decoded only from registered state/index/buffer. There is no combinational path from `c_flat` or `m_ready` to any output.

## Test plan
- Reset/no spurious capture: hold `done`=1 through reset release for 5 cycles → `m_valid` stays 0, `frame_cnt`=0. Then drop `done` for 1 cycle and raise it → frame starts.
- Single frame, `m_ready`=1, `c_flat` elements 1..9 (A×I, A=[[1,2,3],[4,5,6],[7,8,9]]): `done` rises at t → words 1,2,…,9 on cycles t+1…t+9, `m_index` 0..8, `m_last` only with 9. `frame_cnt`=1 and `busy`=0 at t+10.
- Backpressure: `m_ready` pattern 1,0,0,1,0,… → each of 1..9 is accepted exactly once, in order. Data and index stay stable during stalls.
- Snapshot isolation: after capture, set all `c_flat` elements to 0xFFFF → streamed values remain 1..9. The next frame (after `done` goes low then high) outputs 0xFFFF ×9.
- Overrun: during beat 4, toggle `done` low then high → `overrun`=1, stream completes 1..9 with no second frame. Pulse `clr_err` → `overrun`=0.
- Reset mid-stream: assert `rst_n`=0 after word 5 is accepted → outputs return to reset values immediately. After release and a new `done` rise, the stream restarts at index 0 with value 1.
